alu_exception_unit: RTL and testbench
=====================================

Name: alu_exception_unit

Overview:
- Consumes the ALU's 8-bit status flags alongside each committing instruction's PC.
- Accumulates sticky flags, detects trapping conditions (divide-by-zero, invalid address, signed overflow), and raises a registered exception request to the control unit.
- Holds that request until acknowledged, then stalls the pipeline for a fixed flush window.
- Sits between the ALU status output and the main controller / PC-select logic.

Parameters:
- FLUSH_CYCLES, 2, cycles stall stays high after exc_ack (0 = return to IDLE immediately)
- COUNT_W, 8, width of the saturating exception counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset
- status_valid  input  1  ALU_status/inst_pc describe an instruction committing this cycle
- ALU_status  input  8  [7] zero, [6] overflow, [5] carry, [4] negative, [3] invalid address, [2] divide-by-zero, [1:0] reserved (ignored)
- inst_pc  input  32  PC of the committing instruction
- ovf_trap_en  input  1  1 = signed op (add/sub/mul), overflow traps; 0 = overflow recorded only
- exc_ack  input  1  controller has taken the exception vector
- flags_clr  input  1  clear sticky_flags
- exc_req  output  1  exception pending
- exc_cause  output  4  cause code of last trap
- exc_epc  output  32  PC of trapping instruction
- stall  output  1  pipeline must hold / not commit
- sticky_flags  output  8  OR-accumulated status bits [7:2]; [1:0] always 0
- exc_count  output  COUNT_W  number of traps taken, saturating

Behaviour:
- Clock and reset: one clock (clk); reset (rst_n) is asynchronous and active-low. All state updates on the rising edge of clk.
- Reset values: state=IDLE; exc_req=0, exc_cause=0, exc_epc=0, stall=0, sticky_flags=0, exc_count=0, flush counter=0. Reset asserted mid-TRAP or mid-FLUSH forces IDLE and clears all outputs immediately.
- Accept rule: a status is accepted when status_valid=1 and state=IDLE. When stall=1, status_valid is ignored entirely: no sticky update, no trap.
- Trap detection on accept, fixed priority:
  - ALU_status[2] -> cause 4'hD (div0)
  - else ALU_status[3] -> cause 4'h4 (address)
  - else ALU_status[6] with ovf_trap_en=1 -> cause 4'hC (overflow)
  - otherwise no trap.
- Trap latency: accept at edge N with a trap gives, from N+1:
  - exc_req=1, stall=1, exc_cause=code, exc_epc=inst_pc
  - exc_count incremented, saturating at all-ones; state=TRAP.
- TRAP state:
  - exc_req and stall held high, exc_cause and exc_epc held stable.
  - When exc_ack=1 is sampled: exc_req=0 from the next cycle.
  - Then go to FLUSH with the counter loaded to FLUSH_CYCLES-1, or to IDLE with stall=0 if FLUSH_CYCLES=0.
- FLUSH state: stall=1, exc_req=0; counter decrements each cycle; at 0 -> IDLE, stall=0 the next cycle. Total stall after the ack edge = FLUSH_CYCLES cycles.
- exc_ack while in IDLE or FLUSH is ignored.
- exc_cause and exc_epc persist after the trap until the next trap overwrites them.
- Sticky flags:
  - On every accept: sticky_flags[7:2] |= ALU_status[7:2]. This includes the trapping accept, and overflow with ovf_trap_en=0.
  - flags_clr=1 clears sticky_flags; it is honoured in any state.
  - Simultaneous flags_clr and accept: result = ALU_status[7:2] of the new accept (clear of old bits, then set).
- Non-trapping accepts (zero, carry, negative only) update sticky_flags only; stall stays 0.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset, then accept ALU_status=8'h80 (zero) -> exc_req=0, stall=0, sticky_flags=8'h80, exc_count=0.
- Accept ALU_status=8'h04, inst_pc=32'h0000_0040 -> next cycle exc_req=1, stall=1, exc_cause=4'hD, exc_epc=32'h40, exc_count=1. Hold exc_ack=0 for 5 cycles -> all outputs stable. Pulse exc_ack -> exc_req=0 next cycle, stall=1 for exactly 2 cycles, then 0.
- Accept 8'h4C (overflow+address+div0) -> exc_cause=4'hD (priority). Accept 8'h40 with ovf_trap_en=0 -> no trap, sticky_flags[6]=1. Accept 8'h40 with ovf_trap_en=1 -> exc_cause=4'hC.
- During TRAP, drive status_valid=1, ALU_status=8'h08, inst_pc=32'h80 -> ignored: exc_epc unchanged, sticky_flags[3] unchanged, exc_count unchanged.
- sticky_flags=8'h90; flags_clr=1 with an accept of 8'h20 in the same cycle -> sticky_flags=8'h20. Assert rst_n=0 mid-FLUSH -> stall=0, exc_count=0 immediately.
- COUNT_W=2: take 5 traps -> exc_count saturates at 3. FLUSH_CYCLES=0: ack -> stall=0 on the same cycle exc_req drops.

Source files
------------

// File: rtl/alu_exception_unit_if.sv
// Interface between the ALU status / controller side and alu_exception_unit.
// The unit sits on the slave side. The controller and ALU status source sit on the master side.
interface alu_exception_unit_if #(
  parameter int COUNT_W = 8
);
  logic               status_valid;
  logic [7:0]         ALU_status;
  logic [31:0]        inst_pc;
  logic               ovf_trap_en;
  logic               exc_ack;
  logic               flags_clr;
  logic               exc_req;
  logic [3:0]         exc_cause;
  logic [31:0]        exc_epc;
  logic               stall;
  logic [7:0]         sticky_flags;
  logic [COUNT_W-1:0] exc_count;

  modport master (
    output status_valid, ALU_status, inst_pc, ovf_trap_en, exc_ack, flags_clr,
    input  exc_req, exc_cause, exc_epc, stall, sticky_flags, exc_count
  );

  modport slave (
    input  status_valid, ALU_status, inst_pc, ovf_trap_en, exc_ack, flags_clr,
    output exc_req, exc_cause, exc_epc, stall, sticky_flags, exc_count
  );
endinterface

// File: rtl/alu_exception_unit.sv
// ALU exception unit: sticky status flags, prioritised trap detection,
// held exception request until acknowledged, then a fixed flush stall.
module alu_exception_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int COUNT_W      = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_exception_unit_if.slave bus
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t             state_r, next_state_s;
  logic               exc_req_r;
  logic               stall_r;
  logic [3:0]         exc_cause_r, next_cause_s;
  logic [31:0]        exc_epc_r, next_epc_s;
  logic [7:0]         sticky_r, next_sticky_s;
  logic [COUNT_W-1:0] count_r, next_count_s;
  logic [FC_W-1:0]    flush_cnt_r, next_flush_s;
  logic               accept_s;
  logic [4:0]         trap_s;

  // Returns {trap_hit, cause}; divide-by-zero beats address beats overflow.
  function automatic logic [4:0] trap_decode(input logic [7:0] st, input logic ovf_en);
    logic [4:0] res;
    if (st[2]) begin
      res = {1'b1, 4'hD};
    end else if (st[3]) begin
      res = {1'b1, 4'h4};
    end else if (st[6] && ovf_en) begin
      res = {1'b1, 4'hC};
    end else begin
      res = {1'b0, 4'h0};
    end
    return res;
  endfunction

  assign accept_s = bus.status_valid && (state_r == IDLE);
  assign trap_s   = trap_decode(bus.ALU_status, bus.ovf_trap_en);

  // Next-state and next-value logic for all registered state.
  always_comb begin
    next_state_s  = state_r;
    next_cause_s  = exc_cause_r;
    next_epc_s    = exc_epc_r;
    next_count_s  = count_r;
    next_flush_s  = flush_cnt_r;
    next_sticky_s = bus.flags_clr ? 8'h00 : sticky_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          // Reserved bits [1:0] are masked so they never become sticky.
          next_sticky_s = next_sticky_s | (bus.ALU_status & 8'b1111_1100);
          if (trap_s[4]) begin
            next_state_s = TRAP;
            next_cause_s = trap_s[3:0];
            next_epc_s   = bus.inst_pc;
            if (count_r != {COUNT_W{1'b1}}) begin
              next_count_s = count_r + COUNT_W'(1);
            end else begin
              next_count_s = count_r;
            end
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      TRAP: begin
        if (bus.exc_ack) begin
          if (FLUSH_CYCLES == 0) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = FLUSH;
            next_flush_s = FC_W'(FLUSH_CYCLES - 1);
          end
        end else begin
          next_state_s = TRAP;
        end
      end
      FLUSH: begin
        if (flush_cnt_r == {FC_W{1'b0}}) begin
          next_state_s = IDLE;
        end else begin
          next_flush_s = flush_cnt_r - FC_W'(1);
        end
      end
      default: begin
        next_state_s = IDLE;
        next_flush_s = {FC_W{1'b0}};
      end
    endcase
  end

  // State and output registers; req/stall follow the next state so outputs stay registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      exc_req_r   <= 1'b0;
      stall_r     <= 1'b0;
      exc_cause_r <= 4'h0;
      exc_epc_r   <= 32'h0000_0000;
      sticky_r    <= 8'h00;
      count_r     <= {COUNT_W{1'b0}};
      flush_cnt_r <= {FC_W{1'b0}};
    end else begin
      state_r     <= next_state_s;
      exc_req_r   <= (next_state_s == TRAP);
      stall_r     <= (next_state_s != IDLE);
      exc_cause_r <= next_cause_s;
      exc_epc_r   <= next_epc_s;
      sticky_r    <= next_sticky_s;
      count_r     <= next_count_s;
      flush_cnt_r <= next_flush_s;
    end
  end

  assign bus.exc_req      = exc_req_r;
  assign bus.stall        = stall_r;
  assign bus.exc_cause    = exc_cause_r;
  assign bus.exc_epc      = exc_epc_r;
  assign bus.sticky_flags = sticky_r;
  assign bus.exc_count    = count_r;

endmodule

// File: tb/tb_alu_exception_unit.sv
// Directed bench for alu_exception_unit: a vector table for the main flow,
// plus hand sequences for async reset, counter saturation and zero flush.
module tb_alu_exception_unit;

  logic        clk;
  logic        rst_n;
  logic        status_valid;
  logic [7:0]  alu_st;
  logic [31:0] inst_pc;
  logic        ovf_trap_en;
  logic        exc_ack;
  logic        flags_clr;

  int n_cmp;
  int n_bad;

  alu_exception_unit_if #(.COUNT_W(8)) if0 ();
  alu_exception_unit_if #(.COUNT_W(2)) if1 ();

  assign if0.status_valid = status_valid;
  assign if0.ALU_status   = alu_st;
  assign if0.inst_pc      = inst_pc;
  assign if0.ovf_trap_en  = ovf_trap_en;
  assign if0.exc_ack      = exc_ack;
  assign if0.flags_clr    = flags_clr;
  assign if1.status_valid = status_valid;
  assign if1.ALU_status   = alu_st;
  assign if1.inst_pc      = inst_pc;
  assign if1.ovf_trap_en  = ovf_trap_en;
  assign if1.exc_ack      = exc_ack;
  assign if1.flags_clr    = flags_clr;

  alu_exception_unit #(.FLUSH_CYCLES(2), .COUNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  alu_exception_unit #(.FLUSH_CYCLES(0), .COUNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  st;
    logic [31:0] pc;
    logic        ovf;
    logic        ack;
    logic        clr;
    logic        e_req;
    logic [3:0]  e_cause;
    logic [31:0] e_epc;
    logic        e_stall;
    logic [7:0]  e_sticky;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] st, input logic [31:0] pc,
                     input logic ovf, input logic ack, input logic clr,
                     input logic rq, input logic [3:0] ca, input logic [31:0] ep,
                     input logic sl, input logic [7:0] sf, input logic [7:0] cn);
    vec_t x;
    x.v = v; x.st = st; x.pc = pc; x.ovf = ovf; x.ack = ack; x.clr = clr;
    x.e_req = rq; x.e_cause = ca; x.e_epc = ep; x.e_stall = sl; x.e_sticky = sf; x.e_cnt = cn;
    vq.push_back(x);
  endtask

  task automatic drive(input logic v, input logic [7:0] st, input logic [31:0] pc,
                       input logic ovf, input logic ack, input logic clr);
    status_valid = v; alu_st = st; inst_pc = pc; ovf_trap_en = ovf; exc_ack = ack; flags_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input vec_t x);
    chk({tag, ".exc_req"},      {31'd0, if0.exc_req},      {31'd0, x.e_req});
    chk({tag, ".exc_cause"},    {28'd0, if0.exc_cause},    {28'd0, x.e_cause});
    chk({tag, ".exc_epc"},      if0.exc_epc,               x.e_epc);
    chk({tag, ".stall"},        {31'd0, if0.stall},        {31'd0, x.e_stall});
    chk({tag, ".sticky_flags"}, {24'd0, if0.sticky_flags}, {24'd0, x.e_sticky});
    chk({tag, ".exc_count"},    {24'd0, if0.exc_count},    {24'd0, x.e_cnt});
  endtask

  task automatic do_reset();
    status_valid = 1'b0; alu_st = 8'h00; inst_pc = 32'h0; ovf_trap_en = 1'b0;
    exc_ack = 1'b0; flags_clr = 1'b0;
    #2 rst_n = 1'b0;
    #13 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t r0;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    do_reset();
    r0.e_req = 1'b0; r0.e_cause = 4'h0; r0.e_epc = 32'h0; r0.e_stall = 1'b0;
    r0.e_sticky = 8'h00; r0.e_cnt = 8'h00;
    chk0("reset", r0);

    //   v     st     pc    ovf   ack   clr | req  cause  epc   stall sticky cnt
    add(1'b1, 8'h80, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h00, 1'b0, 8'h80, 8'd0);
    add(1'b1, 8'h04, 32'h40, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 32'h40, 1'b1, 8'h84, 8'd1);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 32'h40, 1'b1, 8'h84, 8'd1);
    add(1'b1, 8'h08, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 32'h40, 1'b1, 8'h84, 8'd1);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 32'h40, 1'b1, 8'h84, 8'd1);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 32'h40, 1'b1, 8'h84, 8'd1);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 32'h40, 1'b1, 8'h84, 8'd1);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'hD, 32'h40, 1'b1, 8'h84, 8'd1);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD, 32'h40, 1'b1, 8'h84, 8'd1);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD, 32'h40, 1'b0, 8'h84, 8'd1);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'hD, 32'h40, 1'b0, 8'h84, 8'd1);
    add(1'b1, 8'h4C, 32'h44, 1'b0, 1'b0, 1'b0, 1'b1, 4'hD, 32'h44, 1'b1, 8'hCC, 8'd2);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'hD, 32'h44, 1'b1, 8'hCC, 8'd2);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD, 32'h44, 1'b1, 8'hCC, 8'd2);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'hD, 32'h44, 1'b0, 8'hCC, 8'd2);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'hD, 32'h44, 1'b0, 8'h00, 8'd2);
    add(1'b1, 8'h40, 32'h48, 1'b0, 1'b0, 1'b0, 1'b0, 4'hD, 32'h44, 1'b0, 8'h40, 8'd2);
    add(1'b1, 8'h40, 32'h4C, 1'b1, 1'b0, 1'b0, 1'b1, 4'hC, 32'h4C, 1'b1, 8'h40, 8'd3);
    add(1'b1, 8'h08, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1, 4'hC, 32'h4C, 1'b1, 8'h40, 8'd3);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC, 32'h4C, 1'b1, 8'h40, 8'd3);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC, 32'h4C, 1'b1, 8'h00, 8'd3);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 32'h4C, 1'b0, 8'h00, 8'd3);
    add(1'b1, 8'h90, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0, 4'hC, 32'h4C, 1'b0, 8'h90, 8'd3);
    add(1'b1, 8'h20, 32'h54, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC, 32'h4C, 1'b0, 8'h20, 8'd3);
    add(1'b1, 8'h0B, 32'h58, 1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 32'h58, 1'b1, 8'h28, 8'd4);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4, 32'h58, 1'b1, 8'h28, 8'd4);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 32'h58, 1'b1, 8'h28, 8'd4);
    add(1'b0, 8'h00, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 32'h58, 1'b0, 8'h28, 8'd4);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].st, vq[i].pc, vq[i].ovf, vq[i].ack, vq[i].clr);
      chk0($sformatf("vec%0d", i), vq[i]);
    end

    // Async reset in the middle of the flush window.
    drive(1'b1, 8'h04, 32'h60, 1'b0, 1'b0, 1'b0);
    chk("rst_seq.trap_req", {31'd0, if0.exc_req}, 32'd1);
    drive(1'b0, 8'h00, 32'h00, 1'b0, 1'b1, 1'b0);
    chk("rst_seq.flush_stall", {31'd0, if0.stall}, 32'd1);
    exc_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seq.stall",  {31'd0, if0.stall}, 32'd0);
    chk("rst_seq.count",  {24'd0, if0.exc_count}, 32'd0);
    chk("rst_seq.sticky", {24'd0, if0.sticky_flags}, 32'd0);
    chk("rst_seq.epc",    if0.exc_epc, 32'd0);
    #3 rst_n = 1'b1;

    // Zero flush window and 2-bit counter saturation on the second instance.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      drive(1'b1, 8'h04, 32'h100 + 32'(t), 1'b0, 1'b0, 1'b0);
      chk($sformatf("sat%0d.req", t),   {31'd0, if1.exc_req},   32'd1);
      chk($sformatf("sat%0d.count", t), {30'd0, if1.exc_count}, (t < 3) ? 32'(t + 1) : 32'd3);
      drive(1'b0, 8'h00, 32'h00, 1'b0, 1'b1, 1'b0);
      chk($sformatf("sat%0d.ack_req", t),   {31'd0, if1.exc_req}, 32'd0);
      chk($sformatf("sat%0d.ack_stall", t), {31'd0, if1.stall},   32'd0);
    end
    chk("sat.epc", if1.exc_epc, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
